// File: rtl/cayde_pkg.sv
// Shared encodings for the cayde decode stage: ALU op codes, RV32I opcode
// and funct7 constants, and the packed decoded-command record.
package cayde_pkg;

    typedef enum logic [6:0] {
        ALU_ADD = 7'd0,
        ALU_SUB = 7'd1,
        ALU_XOR = 7'd2,
        ALU_AND = 7'd3,
        ALU_OR  = 7'd4,
        ALU_SLL = 7'd6,
        ALU_SRL = 7'd8,
        ALU_SRA = 7'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [6:0]  alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } decode_t;

endpackage

// File: rtl/cayde_alu_decode_comb.sv
// Purely combinational RV32I decoder for OP, OP-IMM and LUI; every other
// encoding is reported illegal with all command fields forced to zero.
module cayde_alu_decode_comb
    import cayde_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [6:0]  alu_op_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic        use_imm_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i_sext;
    logic [31:0] imm_shamt;

    alu_op_e     op;
    logic        legal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign imm_i_sext = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_shamt  = {27'b0, instr_i[24:20]};

    always_comb begin
        op      = ALU_ADD;
        legal   = 1'b0;
        rs1     = instr_i[19:15];
        rs2     = instr_i[24:20];
        imm     = '0;
        use_imm = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  op = ALU_ADD;
                        3'b100:  op = ALU_XOR;
                        3'b111:  op = ALU_AND;
                        3'b110:  op = ALU_OR;
                        3'b001:  op = ALU_SLL;
                        3'b101:  op = ALU_SRL;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  op = ALU_SUB;
                        3'b101:  op = ALU_SRA;
                        default: legal = 1'b0;
                    endcase
                end
            end

            OPC_OPIMM: begin
                use_imm = 1'b1;
                rs2     = '0;
                case (funct3)
                    3'b000: begin op = ALU_ADD; imm = imm_i_sext; legal = 1'b1; end
                    3'b100: begin op = ALU_XOR; imm = imm_i_sext; legal = 1'b1; end
                    3'b111: begin op = ALU_AND; imm = imm_i_sext; legal = 1'b1; end
                    3'b110: begin op = ALU_OR;  imm = imm_i_sext; legal = 1'b1; end
                    3'b001: begin
                        op    = ALU_SLL;
                        imm   = imm_shamt;
                        legal = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        imm   = imm_shamt;
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    default: legal = 1'b0;
                endcase
            end

            OPC_LUI: begin
                op      = ALU_ADD;
                rs1     = '0;
                rs2     = '0;
                imm     = {instr_i[31:12], 12'b0};
                use_imm = 1'b1;
                legal   = 1'b1;
            end

            default: legal = 1'b0;
        endcase
    end

    // Illegal words carry rd=0 so nothing downstream can write back.
    assign alu_op_o  = legal ? op      : ALU_ADD;
    assign rs1_o     = legal ? rs1     : '0;
    assign rs2_o     = legal ? rs2     : '0;
    assign rd_o      = legal ? instr_i[11:7] : '0;
    assign imm_o     = legal ? imm     : '0;
    assign use_imm_o = legal ? use_imm : 1'b0;
    assign illegal_o = !legal;

endmodule

// File: rtl/cayde_alu_decode.sv
// cayde decode stage: one-deep registered output with valid/ready handshake,
// flush, and a saturating count of accepted illegal instructions.
module cayde_alu_decode
    import cayde_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [6:0]       alu_op_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic [31:0]      imm_o,
    output logic             use_imm_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    decode_t          dec_w;
    decode_t          dec_q;
    decode_t          dec_d;
    logic             valid_q;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    cayde_alu_decode_comb u_comb (
        .instr_i   (instr_i),
        .alu_op_o  (dec_w.alu_op),
        .rs1_o     (dec_w.rs1),
        .rs2_o     (dec_w.rs2),
        .rd_o      (dec_w.rd),
        .imm_o     (dec_w.imm),
        .use_imm_o (dec_w.use_imm),
        .illegal_o (dec_w.illegal)
    );

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    // Flush wins over both accept and drain; data fields only move on accept.
    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = dec_w;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end

        if (accept && dec_w.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign alu_op_o      = dec_q.alu_op;
    assign rs1_o         = dec_q.rs1;
    assign rs2_o         = dec_q.rs2;
    assign rd_o          = dec_q.rd;
    assign imm_o         = dec_q.imm;
    assign use_imm_o     = dec_q.use_imm;
    assign illegal_o     = dec_q.illegal;
    assign illegal_cnt_o = cnt_q;

endmodule

// File: doc/cayde_alu_decode.md
Name: cayde_alu_decode

Overview:
Pipelined instruction-decode stage for the cayde core. It produces the 7-bit ALU operation codes consumed by the ALU, plus register indices and the immediate. It accepts 32-bit RV32I instructions on a valid/ready handshake and decodes OP, OP-IMM and LUI into a registered ALU command. Unsupported encodings are flagged illegal and counted.

Parameters:
CNT_W, 16, width of the saturating illegal-instruction counter

Ports:
clk_i  in  1  core clock; all state updates on the rising edge
rst_i  in  1  asynchronous, active-high reset
in_valid_i  in  1  instruction word valid
in_ready_o  out  1  stage can accept an instruction this cycle
instr_i  in  32  RV32I instruction word
flush_i  in  1  discard the held output and any instruction offered this cycle
out_valid_o  out  1  decoded command valid
out_ready_i  in  1  downstream accepts the command
alu_op_o  out  7  ALU operation code (package encoding)
rs1_o  out  5  source register 1 index
rs2_o  out  5  source register 2 index
rd_o  out  5  destination register index
imm_o  out  32  immediate operand
use_imm_o  out  1  1: operand B = imm_o, 0: operand B = rs2
illegal_o  out  1  decoded word is unsupported
illegal_cnt_o  out  CNT_W  count of accepted illegal words, saturating

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0, all data outputs 0, illegal_cnt_o=0. An instruction in flight is lost.
- in_ready_o = !out_valid_o || out_ready_i (combinational). Accept = in_valid_i && in_ready_o && !flush_i.
- On accept: decoded fields are registered; out_valid_o=1 on the next edge (latency 1 cycle).
- When out_valid_o && out_ready_i and no accept occurs, out_valid_o clears on the next edge.
- With out_valid_o=1 and out_ready_i=0, all outputs hold stable.
- flush_i has priority: on the next edge out_valid_o=0 and the offered instruction is dropped. The counter is not incremented for a flushed word.
- OP (0110011), funct7=0000000: funct3 000 ADD(0), 100 XOR(2), 111 AND(3), 110 OR(4), 001 SLL(6), 101 SRL(8). use_imm=0.
- OP with funct7=0100000: funct3 000 SUB(1), 101 SRA(9).
- OP-IMM (0010011): funct3 000/100/111/110 -> ADD/XOR/AND/OR. imm = sign-extended instr[31:20]. use_imm=1, rs2_o=0.
- OP-IMM shifts: funct3 001 with funct7=0000000 -> SLL. funct3 101 with funct7=0000000 -> SRL, with 0100000 -> SRA. imm = zero-extended instr[24:20].
- LUI (0110111): ADD, rs1_o=0, imm = {instr[31:12],12'b0}, use_imm=1.
- All other encodings are illegal, including SLT/SLTU/SLTI/SLTIU, bad funct7, and other opcodes. Output: illegal_o=1, alu_op=0, rd_o=0 (no writeback), rs1/rs2/imm=0, use_imm=0.
- illegal_cnt_o increments by 1 per accepted illegal word and saturates at 2^CNT_W-1. It is cleared only by reset.
- Back-to-back: an accept and a downstream take in the same cycle keep out_valid_o=1 with the new fields. Full throughput is 1 instruction/cycle.

Decomposition:
- Package cayde_pkg holds the ALU op localparams: ALU_ADD=0, ALU_SUB=1, ALU_XOR=2, ALU_AND=3, ALU_OR=4, ALU_SLL=6, ALU_SRL=8, ALU_SRA=9.
- cayde_pkg also holds the opcode constants OPC_OP, OPC_OPIMM, OPC_LUI and the funct7 constants F7_BASE, F7_ALT.
- One combinational sub-module, cayde_alu_decode_comb: instr -> {alu_op, rs1, rs2, rd, imm, use_imm, illegal}. The top level owns the handshake register and the counter.

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready_i=1 -> next cycle: out_valid_o=1, alu_op=0, rd=1, rs1=0, imm=5, use_imm=1, illegal=0.
- SUB x3,x1,x2 (0x402081B3) -> alu_op=1, rs1=1, rs2=2, rd=3, use_imm=0.
- SRAI x5,x6,3 (0x40335293) -> alu_op=9, rs1=6, rd=5, imm=3, use_imm=1.
- Hold out_ready_i=0 for 3 cycles after a valid output -> in_ready_o=0 and outputs unchanged. Raise out_ready_i -> next word accepted that cycle.
- SLT x0,x0,x0 (0x00002033) -> illegal_o=1, rd=0, illegal_cnt_o 0->1. Flush the same word instead -> counter stays 0 and out_valid_o=0.
- Assert rst_i asynchronously while out_valid_o=1 -> out_valid_o=0 and counter=0 immediately, without waiting for a clock edge.
